multi_button_vote_ctrl: RTL and testbench

- Parametrised successor to the single-button vote debouncer. Serves NUM_BUTTONS candidate buttons.
- Per channel: synchronises the raw input, debounces it with a programmable stable-time counter, and emits exactly one vote pulse per qualified press, tagged with the channel index.
- Blocks simultaneous/overlapping presses and re-triggering until all buttons have been stably released.
- Sits between the board push-buttons and the vote-tally logic.

---
 rtl/multi_button_vote_ctrl.sv | 149 ++++++++++++++
 tb/tb_multi_button_vote_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_button_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_button_vote_ctrl
// Brief    : N-channel push-button vote debouncer with ambiguity rejection.
// Revision : 1.0 - initial release
// ============================================================================
module multi_button_vote_ctrl #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic                   valid_vote,
    output logic [IDX_W-1:0]       vote_index,
    output logic                   multi_press,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] c_deb_max  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W:0]   c_one      = (IDX_W+1)'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [CNT_W-1:0]       r_press_cnt [NUM_BUTTONS];
    logic [CNT_W-1:0]       r_rel_cnt;
    logic [NUM_BUTTONS-1:0] w_qual;
    logic [IDX_W:0]         w_qual_num;
    logic [IDX_W:0]         w_high_num;
    logic [IDX_W-1:0]       w_qual_idx;
    logic                   w_rel_done;
    logic                   w_vote;
    logic                   w_multi;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    // Counter saturates so a long hold never produces a second qualification
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_press_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (!r_sync2[i]) begin
                    r_press_cnt[i] <= '0;
                end else if (r_press_cnt[i] != c_deb_max) begin
                    r_press_cnt[i] <= r_press_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_qual     = '0;
        w_qual_num = '0;
        w_high_num = '0;
        w_qual_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_qual[i]  = r_sync2[i] && (r_press_cnt[i] == c_deb_last);
            w_qual_num = w_qual_num + (IDX_W+1)'(w_qual[i]);
            w_high_num = w_high_num + (IDX_W+1)'(r_sync2[i]);
            if (w_qual[i]) begin
                w_qual_idx = IDX_W'(i);
            end
        end
    end

    assign w_rel_done = (r_state == HELD) && (r_sync2 == '0) && (r_rel_cnt == c_deb_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rel_cnt <= '0;
        end else if ((r_state != HELD) || (r_sync2 != '0) || w_rel_done) begin
            r_rel_cnt <= '0;
        end else begin
            r_rel_cnt <= r_rel_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A lone qualifier votes; any other held channel makes the press ambiguous
    always_comb begin
        w_state_nxt = r_state;
        w_vote      = 1'b0;
        w_multi     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && (w_qual != '0)) begin
                    w_state_nxt = HELD;
                    if ((w_qual_num == c_one) && (w_high_num == c_one)) begin
                        w_vote = 1'b1;
                    end else begin
                        w_multi = 1'b1;
                    end
                end
            end
            HELD: begin
                if (w_rel_done) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_vote  <= 1'b0;
            multi_press <= 1'b0;
            vote_index  <= '0;
        end else begin
            valid_vote  <= w_vote;
            multi_press <= w_multi;
            if (w_vote) begin
                vote_index <= w_qual_idx;
            end
        end
    end

    assign busy = (r_state == HELD);

endmodule
`default_nettype wire

// File: tb/tb_multi_button_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_button_vote_ctrl
// Brief    : Scenario and random bench against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_button_vote_ctrl;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] button = '0;
    logic         valid_vote;
    logic         multi_press;
    logic         busy;
    logic [1:0]   vote_index;

    int checks = 0;
    int passes = 0;
    int n_vote, n_multi, n_busy, n_vote_post;

    multi_button_vote_ctrl #(
        .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .IDX_W(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .button(button),
        .valid_vote(valid_vote), .vote_index(vote_index),
        .multi_press(multi_press), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference model: s is the button two edges late; run lengths of synced
    // highs per channel and of all-low cycles while a press is held.
    bit [N-1:0] m_p1, m_p2;
    int         m_run [N];
    int         m_low;
    bit         m_held, e_valid, e_multi;
    bit [1:0]   e_idx;

    function automatic bit [N-1:0] m_qual();
        bit [N-1:0] q = '0;
        for (int i = 0; i < N; i++) q[i] = m_p2[i] && (m_run[i] == D);
        return q;
    endfunction

    function automatic int m_first(input bit [N-1:0] q);
        for (int i = 0; i < N; i++) if (q[i]) return i;
        return 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_p1 <= '0; m_p2 <= '0; m_low <= 0; m_held <= 1'b0;
            e_valid <= 1'b0; e_multi <= 1'b0; e_idx <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            m_p1 <= button;
            m_p2 <= m_p1;
            for (int i = 0; i < N; i++)
                m_run[i] <= m_p1[i] ? ((m_run[i] > D) ? m_run[i] : m_run[i] + 1) : 0;
            e_valid <= 1'b0;
            e_multi <= 1'b0;
            if (!m_held) begin
                if (enable && (m_qual() != '0)) begin
                    m_held <= 1'b1;
                    if ($countones(m_qual()) == 1 && $countones(m_p2) == 1) begin
                        e_valid <= 1'b1;
                        e_idx   <= 2'(m_first(m_qual()));
                    end else begin
                        e_multi <= 1'b1;
                    end
                end
            end else if (m_p2 != '0) begin
                m_low <= 0;
            end else if (m_low + 1 == D) begin
                m_low  <= 0;
                m_held <= 1'b0;
            end else begin
                m_low <= m_low + 1;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({valid_vote, multi_press, busy, vote_index} !== 5'b0)
            $display("FAIL reset_state: got %b want 00000", {valid_vote, multi_press, busy, vote_index});
        else passes++;
        reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_vote();
        n_vote = 0; n_multi = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL single_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            if (c == 0) button[2] = 1'b1;
            if (c == 20) button[2] = 1'b0;
        end
        checks++;
        if (n_vote != 1 || n_multi != 0 || vote_index !== 2'd2)
            $display("FAIL single_summary: votes=%0d multi=%0d idx=%0d want 1 0 2", n_vote, n_multi, vote_index);
        else passes++;
    endtask

    task automatic test_glitch();
        n_vote = 0; n_multi = 0; n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL glitch_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            if (busy) n_busy++;
            if (c == 0 || c == 4) button[1] = 1'b1;
            if (c == 3 || c == 7) button[1] = 1'b0;
        end
        checks++;
        if (n_vote != 0 || n_multi != 0 || n_busy != 0)
            $display("FAIL glitch_summary: votes=%0d multi=%0d busy=%0d want 0 0 0", n_vote, n_multi, n_busy);
        else passes++;
    endtask

    task automatic test_simultaneous();
        n_vote = 0; n_multi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL simul_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            if (c == 0) begin button[0] = 1'b1; button[3] = 1'b1; end
            if (c == 10) begin button[0] = 1'b0; button[3] = 1'b0; end
        end
        checks++;
        if (n_vote != 0 || n_multi != 1 || vote_index !== 2'd2)
            $display("FAIL simul_summary: votes=%0d multi=%0d idx=%0d want 0 1 2", n_vote, n_multi, vote_index);
        else passes++;
    endtask

    task automatic test_overlap();
        n_vote = 0; n_multi = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL overlap_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            if (c == 0) button[1] = 1'b1;
            if (c == 2 || c == 25) button[2] = 1'b1;
            if (c == 12) begin button[1] = 1'b0; button[2] = 1'b0; end
            if (c == 35) button[2] = 1'b0;
        end
        checks++;
        if (n_vote != 1 || n_multi != 1 || vote_index !== 2'd2)
            $display("FAIL overlap_summary: votes=%0d multi=%0d idx=%0d want 1 1 2", n_vote, n_multi, vote_index);
        else passes++;
    endtask

    task automatic test_enable_gate();
        n_vote = 0; n_multi = 0;
        enable = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL enable_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            if (c == 0 || c == 26) button[3] = 1'b1;
            if (c == 10) enable = 1'b1;
            if (c == 16 || c == 36) button[3] = 1'b0;
        end
        checks++;
        if (n_vote != 1 || n_multi != 0 || vote_index !== 2'd3)
            $display("FAIL enable_summary: votes=%0d multi=%0d idx=%0d want 1 0 3", n_vote, n_multi, vote_index);
        else passes++;
    endtask

    task automatic test_reset_mid_hold();
        n_vote_post = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL rstmid_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            if (valid_vote && c > 9) n_vote_post++;
            if (c == 0) button[0] = 1'b1;
            if (c == 8) begin
                reset = 1'b0;
                #1;
                checks++;
                if ({valid_vote, multi_press, busy, vote_index} !== 5'b0)
                    $display("FAIL rstmid_async: got %b want 00000", {valid_vote, multi_press, busy, vote_index});
                else passes++;
            end
            if (c == 9) reset = 1'b1;
            if (c == 20) button[0] = 1'b0;
        end
        checks++;
        if (n_vote_post != 1 || vote_index !== 2'd0)
            $display("FAIL rstmid_summary: votes=%0d idx=%0d want 1 0", n_vote_post, vote_index);
        else passes++;
    endtask

    task automatic test_random();
        n_vote = 0; n_multi = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            checks++;
            if ({valid_vote, multi_press, busy, vote_index} !== {e_valid, e_multi, m_held, e_idx})
                $display("FAIL random_cycle%0d: got %b want %b", c,
                         {valid_vote, multi_press, busy, vote_index}, {e_valid, e_multi, m_held, e_idx});
            else passes++;
            checks++;
            if (valid_vote && multi_press)
                $display("FAIL random_exclusive%0d: valid=1 multi=1 want not both", c);
            else passes++;
            if (valid_vote) n_vote++;
            if (multi_press) n_multi++;
            enable = ($urandom_range(0, 19) != 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) button[i] = ~button[i];
        end
        button = '0;
        repeat (12) @(negedge clock);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL random_idle: busy=%b want 0", busy);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_glitch();
        test_simultaneous();
        test_overlap();
        test_enable_gate();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
